// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, CTRL bits, reset values.
package timer_pkg;

   // Word offset within the 32-byte window (DataAdr[4:2]).
   typedef enum logic [2:0] {
      TMR_CTRL     = 3'd0,
      TMR_PRESCALE = 3'd1,
      TMR_MTIME_LO = 3'd2,
      TMR_MTIME_HI = 3'd3,
      TMR_CMP_LO   = 3'd4,
      TMR_CMP_HI   = 3'd5,
      TMR_STATUS   = 3'd6,
      TMR_RSVD     = 3'd7
   } tmr_reg_e;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_IRQ_EN   = 1;
   localparam int unsigned CTRL_AUTO_CLR = 2;
   localparam int unsigned CTRL_W        = 3;

   localparam int unsigned STATUS_PENDING = 0;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every reload+1 cycles.
module timer_prescaler #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] reload,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] count;

   assign tick = en & (count == reload);

   // Count register: cleared on reload write, held while disabled, wraps to 0 on tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit timer: decode, register file, prescaled mtime, compare and interrupt.
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        sel,
   output logic        irq
);

   tmr_reg_e              off;
   logic                  wr;
   logic [CTRL_W-1:0]     ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  pending;
   logic                  tick;
   logic                  match;
   logic                  unused_adr;

   assign sel        = (DataAdr[31:5] == BASE_ADDR[31:5]);
   assign off        = tmr_reg_e'(DataAdr[4:2]);
   assign wr         = MemWrite & sel;
   assign unused_adr = ^DataAdr[1:0];

   assign match = ctrl[CTRL_EN] & (mtime >= mtimecmp);
   assign irq   = pending & ctrl[CTRL_IRQ_EN];

   timer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .en     (ctrl[CTRL_EN]),
      .clr    (wr && (off == TMR_PRESCALE)),
      .reload (prescale),
      .tick   (tick)
   );

   // Software-written configuration registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         prescale <= '0;
         mtimecmp <= MTIMECMP_RST;
      end else if (wr) begin
         case (off)
            TMR_CTRL:     ctrl            <= WriteData[CTRL_W-1:0];
            TMR_PRESCALE: prescale        <= WriteData[PRESCALE_W-1:0];
            TMR_CMP_LO:   mtimecmp[31:0]  <= WriteData;
            TMR_CMP_HI:   mtimecmp[63:32] <= WriteData;
            default: ;
         endcase
      end
   end

   // mtime: a software write to either half wins over a tick; that half alone is
   // loaded and the other keeps its pre-edge value (no carry across halves).
   always_ff @(posedge clk) begin
      if (reset) begin
         mtime <= '0;
      end else if (wr && (off == TMR_MTIME_LO)) begin
         mtime[31:0] <= WriteData;
      end else if (wr && (off == TMR_MTIME_HI)) begin
         mtime[63:32] <= WriteData;
      end else if (tick) begin
         if (ctrl[CTRL_AUTO_CLR] && match) begin
            mtime <= '0;
         end else begin
            mtime <= mtime + 64'd1;
         end
      end
   end

   // Sticky pending flag: a match in the same cycle beats a write-1-to-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (match) begin
         pending <= 1'b1;
      end else if (wr && (off == TMR_STATUS) && WriteData[STATUS_PENDING]) begin
         pending <= 1'b0;
      end
   end

   // Combinational read mux of pre-edge register values; zero outside the window.
   always_comb begin
      ReadData = '0;
      if (sel) begin
         case (off)
            TMR_CTRL:     ReadData = 32'(ctrl);
            TMR_PRESCALE: ReadData = 32'(prescale);
            TMR_MTIME_LO: ReadData = mtime[31:0];
            TMR_MTIME_HI: ReadData = mtime[63:32];
            TMR_CMP_LO:   ReadData = mtimecmp[31:0];
            TMR_CMP_HI:   ReadData = mtimecmp[63:32];
            TMR_STATUS:   ReadData = 32'(pending);
            default:      ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: reset-state table plus directed multi-cycle sequences.
module tb_mmio_timer;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        sel;
   logic        irq;

   int unsigned npass;
   int unsigned ntotal;

   localparam logic [31:0] A_CTRL  = 32'h0000_FF00;
   localparam logic [31:0] A_PRE   = 32'h0000_FF04;
   localparam logic [31:0] A_MLO   = 32'h0000_FF08;
   localparam logic [31:0] A_MHI   = 32'h0000_FF0C;
   localparam logic [31:0] A_CLO   = 32'h0000_FF10;
   localparam logic [31:0] A_CHI   = 32'h0000_FF14;
   localparam logic [31:0] A_STAT  = 32'h0000_FF18;
   localparam logic [31:0] A_RSVD  = 32'h0000_FF1C;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] rdata;
      logic        sel;
      logic        irq;
   } rd_vec_t;

   rd_vec_t rst_tbl [10];

   mmio_timer #(
      .BASE_ADDR  (32'h0000_FF00),
      .PRESCALE_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .sel       (sel),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) begin
         npass++;
      end else begin
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // One store cycle; entered and left at posedge+1.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
      DataAdr   = 32'h0;
      WriteData = 32'h0;
   endtask

   // Combinational read check, costs 1 time unit.
   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      DataAdr = a;
      #1;
      chk(nm, {32'h0, ReadData}, {32'h0, exp});
      DataAdr = 32'h0;
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_rst_tbl(input string tag);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         DataAdr = rst_tbl[i].adr;
         #1;
         chk($sformatf("%s rdata[%0d]", tag, i), {32'h0, ReadData}, {32'h0, rst_tbl[i].rdata});
         chk($sformatf("%s sel[%0d]", tag, i), {63'h0, sel}, {63'h0, rst_tbl[i].sel});
         chk($sformatf("%s irq[%0d]", tag, i), {63'h0, irq}, {63'h0, rst_tbl[i].irq});
      end
      DataAdr = 32'h0;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] ac_exp [8];

   initial begin
      npass     = 0;
      ntotal    = 0;
      reset     = 1'b1;
      MemWrite  = 1'b0;
      DataAdr   = 32'h0;
      WriteData = 32'h0;

      rst_tbl[0] = '{A_CTRL, 32'h0,         1'b1, 1'b0};
      rst_tbl[1] = '{A_PRE,  32'h0,         1'b1, 1'b0};
      rst_tbl[2] = '{A_MLO,  32'h0,         1'b1, 1'b0};
      rst_tbl[3] = '{A_MHI,  32'h0,         1'b1, 1'b0};
      rst_tbl[4] = '{A_CLO,  32'hFFFF_FFFF, 1'b1, 1'b0};
      rst_tbl[5] = '{A_CHI,  32'hFFFF_FFFF, 1'b1, 1'b0};
      rst_tbl[6] = '{A_STAT, 32'h0,         1'b1, 1'b0};
      rst_tbl[7] = '{A_RSVD, 32'h0,         1'b1, 1'b0};
      rst_tbl[8] = '{32'h0000_0100, 32'h0,  1'b0, 1'b0};
      rst_tbl[9] = '{32'h0000_FF20, 32'h0,  1'b0, 1'b0};

      ac_exp = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0, 32'd1};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      run_rst_tbl("reset");

      // Prescale 3: first increment 4 edges after enable, 10 after 40 edges.
      wr(A_PRE, 32'd3);
      wr(A_CTRL, 32'd1);
      rd(A_MLO, 32'd0, "pre3 at enable");
      cycles(3);
      rd(A_MLO, 32'd0, "pre3 before first tick");
      cycles(1);
      rd(A_MLO, 32'd1, "pre3 first tick");
      cycles(36);
      rd(A_MLO, 32'd10, "pre3 after 40 cycles");
      wr(A_CTRL, 32'd0);
      cycles(8);
      rd(A_MLO, 32'd10, "disabled freeze");

      // Carry from LO into HI with prescale 0.
      wr(A_PRE, 32'd0);
      wr(A_MLO, 32'hFFFF_FFFF);
      wr(A_MHI, 32'h0);
      wr(A_CTRL, 32'd1);
      rd(A_MLO, 32'hFFFF_FFFF, "carry before");
      cycles(1);
      rd(A_MHI, 32'd1, "carry hi");
      rd(A_MLO, 32'd0, "carry lo");
      wr(A_CTRL, 32'd0);

      // Full 64-bit wrap; all-ones also matches the reset compare value.
      wr(A_MLO, 32'hFFFF_FFFF);
      wr(A_MHI, 32'hFFFF_FFFF);
      wr(A_CTRL, 32'd1);
      cycles(1);
      rd(A_MLO, 32'd0, "wrap lo");
      rd(A_MHI, 32'd0, "wrap hi");
      wr(A_CTRL, 32'd0);
      rd(A_STAT, 32'd1, "wrap match pending");
      chk("wrap irq masked", {63'h0, irq}, 64'h0);
      wr(A_STAT, 32'd1);
      rd(A_STAT, 32'd0, "wrap w1c");

      // Compare at 5 with interrupt enabled.
      wr(A_MLO, 32'd0);
      wr(A_MHI, 32'd0);
      wr(A_CLO, 32'd5);
      wr(A_CHI, 32'd0);
      wr(A_CTRL, 32'd3);
      cycles(5);
      rd(A_MLO, 32'd5, "cmp mtime reaches 5");
      rd(A_STAT, 32'd0, "cmp pending not yet");
      chk("cmp irq not yet", {63'h0, irq}, 64'h0);
      cycles(1);
      rd(A_STAT, 32'd1, "cmp pending set");
      chk("cmp irq set", {63'h0, irq}, 64'h1);
      wr(A_STAT, 32'd1);
      rd(A_STAT, 32'd1, "w1c loses to match");
      wr(A_CLO, 32'd100);
      wr(A_STAT, 32'd1);
      rd(A_STAT, 32'd0, "w1c after cmp raised");
      chk("irq cleared", {63'h0, irq}, 64'h0);
      wr(A_CTRL, 32'd0);

      // Auto-clear with compare 2, prescale 1: mtime 0,1,2,0,...
      wr(A_MLO, 32'd0);
      wr(A_MHI, 32'd0);
      wr(A_CLO, 32'd2);
      wr(A_PRE, 32'd1);
      wr(A_CTRL, 32'd7);
      for (int k = 0; k < 8; k++) begin
         cycles(1);
         rd(A_MLO, ac_exp[k], $sformatf("autoclr step %0d", k + 1));
      end
      rd(A_STAT, 32'd1, "autoclr pending");
      chk("autoclr irq", {63'h0, irq}, 64'h1);

      // Reset while counting with pending set.
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      run_rst_tbl("midreset");

      // MTIME_LO write in the exact tick cycle wins over the increment.
      wr(A_PRE, 32'd3);
      wr(A_CTRL, 32'd1);
      cycles(3);
      wr(A_MLO, 32'h0000_1234);
      rd(A_MLO, 32'h0000_1234, "write beats tick lo");
      rd(A_MHI, 32'h0, "write beats tick hi");
      wr(A_CTRL, 32'd0);

      // Stores outside the window, and to reserved, change nothing.
      wr(32'h0000_0100, 32'hFFFF_FFFF);
      wr(32'h0000_FF20, 32'd7);
      wr(32'h0001_FF08, 32'hDEAD_BEEF);
      wr(32'h0000_FEFC, 32'd5);
      wr(A_RSVD, 32'hFFFF_FFFF);
      rd(A_CTRL, 32'd0, "outside ctrl");
      rd(A_PRE, 32'd3, "outside prescale");
      rd(A_MLO, 32'h0000_1234, "outside mtime lo");
      rd(A_RSVD, 32'd0, "reserved reads 0");
      rd(32'h0000_FF0B, 32'h0000_1234, "byte offset ignored");
      DataAdr = 32'h0000_FF1F;
      #1;
      chk("sel top of window", {63'h0, sel}, 64'h1);
      DataAdr = 32'h0000_FEFF;
      #1;
      chk("sel below window", {63'h0, sel}, 64'h0);
      rd(32'h0001_FF08, 32'h0, "alias rdata zero");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral sitting directly downstream of the single-cycle core's data port, alongside dmem.
- Consumes MemWrite / DataAdr / WriteData and returns read data plus a select flag. Top level muxes its ReadData against dmem.
- Provides a prescaled 64-bit free-running counter (mtime), a 64-bit compare (mtimecmp), a sticky match flag and a level interrupt.

Parameters:
- BASE_ADDR, 32'h0000_FF00, word-aligned base of the 32-byte register window.
- PRESCALE_W, 16, width of the prescaler reload register and counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- MemWrite  input  1  store strobe from core, sampled at posedge clk
- DataAdr  input  32  byte address from core
- WriteData  input  32  store data from core
- ReadData  output  32  combinational read data for DataAdr
- sel  output  1  high when DataAdr falls inside [BASE_ADDR, BASE_ADDR+0x1F]
- irq  output  1  level interrupt = status.pending & ctrl.irq_en

Behaviour:
- Decode:
  - sel = (DataAdr[31:5] == BASE_ADDR[31:5]).
  - Offset = DataAdr[4:2]; DataAdr[1:0] are ignored (word access only).
- Register map, by offset:
  - 0x00 CTRL [0]=en, [1]=irq_en, [2]=auto_clr. Other bits read 0.
  - 0x04 PRESCALE [PRESCALE_W-1:0].
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI.
  - 0x10 CMP_LO.
  - 0x14 CMP_HI.
  - 0x18 STATUS [0]=pending; write-1-to-clear.
  - 0x1C reserved: reads 0, writes ignored.
- Reads:
  - Combinational, same cycle, no latency; reflect register values before this cycle's edge.
  - ReadData = 0 when sel=0.
- Writes: occur at posedge clk when MemWrite & sel. Full 32-bit word; no byte enables.
- Reset (synchronous):
  - CTRL=0, PRESCALE=0, prescaler count=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, pending=0.
  - Outputs: irq=0; ReadData reflects the reset register values.
  - Reset mid-count or with pending set clears everything the same cycle.
- Tick generation:
  - While en=1, the prescaler count increments every cycle.
  - When count == PRESCALE, count goes to 0 and a tick is asserted for that cycle.
  - Tick period is therefore PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
  - en=0 freezes both count and mtime; count is held, not cleared.
- Counting:
  - On a tick, mtime <= mtime+1 as a full 64-bit carry.
  - Wraps from 2^64-1 to 0 with no flag.
- Match:
  - Evaluated combinationally each cycle as en & (mtime >= mtimecmp), unsigned 64-bit.
  - When true, pending <= 1 (sticky).
  - If auto_clr=1 and match is true on a tick cycle, mtime <= 0 instead of incrementing.
- Simultaneous events:
  - A software write to MTIME_LO/HI in a tick cycle wins: the written value is loaded, no increment that cycle. Only the addressed half changes; the other half keeps its pre-edge value, with no carry propagation from the written half.
  - A write to PRESCALE also clears the prescaler count.
  - A STATUS W1C in the same cycle as a true match leaves pending=1 (set wins).
  - A write to CMP_LO/HI takes effect for the match evaluation in the next cycle.
- Torn reads: software must use the HI-LO-HI read sequence. The block provides no snapshot.

Decomposition:
- Shared package (timer_pkg):
  - Register offset constants: TMR_CTRL, TMR_PRESCALE, TMR_MTIME_LO, TMR_MTIME_HI, TMR_CMP_LO, TMR_CMP_HI, TMR_STATUS.
  - CTRL bit indices.
  - Reset value of mtimecmp.
- Sub-module: timer_prescaler (count register, reload compare, tick output, clear input).
- Decode, register file, 64-bit counter and match logic stay in mmio_timer.

Test Plan:
- Reset, then read offsets 0x00..0x1C.
  - Expect 0,0,0,0,FFFFFFFF,FFFFFFFF,0,0; irq=0; sel=0 for DataAdr=0x0000_0100.
- PRESCALE=3, CTRL=1, run 40 cycles.
  - MTIME_LO=10 after 40 cycles; first increment 4 cycles after the en write edge.
- MTIME_LO=FFFF_FFFF, MTIME_HI=0, PRESCALE=0, en=1, one cycle.
  - HI=1, LO=0.
  - Separately, all-ones wraps to 0.
- CMP=5, CTRL=3 (en, irq_en), PRESCALE=0.
  - pending and irq rise the cycle after mtime reaches 5.
  - W1C STATUS while mtime>=5 keeps pending=1.
  - Setting CMP=100 then W1C clears pending and irq.
- CTRL=7, CMP=2, PRESCALE=1.
  - mtime sequence 0,1,2,0,1,2… across ticks; pending set.
- Write MTIME_LO=0x1234 in the exact cycle a tick fires.
  - Reads 0x1234, not 0x1235.
  - MemWrite with DataAdr outside the window changes no register.
